// File: rtl/cnn_pkg.sv
// Shared CNN definitions: sample width, feature-map collector states and
// the output-side helper used to size convolution feature maps.
package cnn_pkg;

  localparam int DATA_W = 13;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } fmap_state_t;

  // Side length of a valid (no padding, stride 1) convolution output.
  function automatic int out_side(input int n, input int m);
    return n - m + 1;
  endfunction

endpackage

// File: rtl/fmap_buf.sv
// Feature-map storage: DEPTH x DW register array with one synchronous write
// port and one combinational read port. Out-of-range reads return zero and
// out-of-range writes are ignored, so the address may safely run one past
// the last entry.
module fmap_buf #(
  parameter int DEPTH = 16,
  parameter int DW    = 13,
  parameter int AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [IW-1:0] widx_s;
  logic [IW-1:0] ridx_s;

  assign widx_s = waddr_i[IW-1:0];
  assign ridx_s = raddr_i[IW-1:0];

  // Storage write; contents carry no reset since every map is rewritten.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < DEPTH_A)) begin
      mem_q[widx_s] <= wdata_i;
    end
  end

  // Read mux with range guard.
  always_comb begin
    if (raddr_i < DEPTH_A) begin
      rdata_o = mem_q[ridx_s];
    end else begin
      rdata_o = {DW{1'b0}};
    end
  end

endmodule

// File: rtl/conv_fmap_collector.sv
// conv_fmap_collector: captures the conv engine's serial result stream into
// an O x O feature map (O = N-M+1), then replays it row-major on a
// valid/ready stream and raises done once the last element is taken.
// Optional build macro: CONV_RELU_EN -- clamp negative samples to zero at
// capture; when undefined, samples are stored and replayed bit-exact.
module conv_fmap_collector
  import cnn_pkg::*;
#(
  parameter int N  = 6,
  parameter int M  = 3,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_en,
  input  logic          clr,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          done,
  output logic          ovf
);

  localparam int O     = out_side(N, M);
  localparam int DEPTH = O * O;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  fmap_state_t   state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          m_last_q, m_last_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic          we_s;
  logic [DW-1:0] wdata_s;
  logic [CW-1:0] rd_addr_s;
  logic [DW-1:0] rd_data_s;
  logic [DW-1:0] next_elem_s;

  // Capture-path value conditioning (optional ReLU).
  always_comb begin
`ifdef CONV_RELU_EN
    if (in_data[DW-1]) begin
      wdata_s = {DW{1'b0}};
    end else begin
      wdata_s = in_data;
    end
`else
    wdata_s = in_data;
`endif
  end

  // Buffer write enable: only while collecting, and clr discards the sample.
  always_comb begin
    if ((state_q == COLLECT) && in_en && !clr) begin
      we_s = 1'b1;
    end else begin
      we_s = 1'b0;
    end
  end

  // Pre-fetch address: element 0 while collecting, the following element while draining.
  always_comb begin
    if (state_q == DRAIN) begin
      rd_addr_s = rd_cnt_q + ONE_C;
    end else begin
      rd_addr_s = {CW{1'b0}};
    end
  end

  // Forward the sample being written when it is the one about to be presented.
  always_comb begin
    if (we_s && (wr_cnt_q == rd_addr_s)) begin
      next_elem_s = wdata_s;
    end else begin
      next_elem_s = rd_data_s;
    end
  end

  fmap_buf #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (CW)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (we_s),
    .waddr_i (wr_cnt_q),
    .wdata_i (wdata_s),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Control FSM next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    if (clr) begin
      state_d   = COLLECT;
      wr_cnt_d  = {CW{1'b0}};
      rd_cnt_d  = {CW{1'b0}};
      m_data_d  = {DW{1'b0}};
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
      done_d    = 1'b0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (in_en) begin
            wr_cnt_d = wr_cnt_q + ONE_C;
            if (wr_cnt_q == LAST_IDX) begin
              state_d   = DRAIN;
              rd_cnt_d  = {CW{1'b0}};
              m_valid_d = 1'b1;
              m_data_d  = next_elem_s;
              m_last_d  = (LAST_IDX == {CW{1'b0}});
            end else begin
              state_d = COLLECT;
            end
          end else begin
            state_d = COLLECT;
          end
        end
        DRAIN: begin
          if (in_en) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (m_valid_q && m_ready) begin
            rd_cnt_d = rd_cnt_q + ONE_C;
            if (m_last_q) begin
              state_d   = DONE;
              m_valid_d = 1'b0;
              m_last_d  = 1'b0;
              done_d    = 1'b1;
            end else begin
              m_data_d = next_elem_s;
              m_last_d = ((rd_cnt_q + ONE_C) == LAST_IDX);
            end
          end else begin
            rd_cnt_d = rd_cnt_q;
          end
        end
        DONE: begin
          if (in_en) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end
        default: begin
          state_d   = COLLECT;
          wr_cnt_d  = {CW{1'b0}};
          rd_cnt_d  = {CW{1'b0}};
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= COLLECT;
      wr_cnt_q  <= {CW{1'b0}};
      rd_cnt_q  <= {CW{1'b0}};
      m_data_q  <= {DW{1'b0}};
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_conv_fmap_collector.sv
// Self-checking bench for conv_fmap_collector: a scoreboard queue is filled
// as samples are pushed and drained/compared as beats are handshaken.
module tb_conv_fmap_collector;

  localparam int DW    = 13;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_en;
  logic          clr;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          done;
  logic          ovf;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] sb_q[$];

  conv_fmap_collector #(.N(6), .M(3), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_en   (in_en),
    .clr     (clr),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .done    (done),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] v);
`ifdef CONV_RELU_EN
    if (v[DW-1]) return {DW{1'b0}};
    return v;
`else
    return v;
`endif
  endfunction

  // Push DEPTH samples base..base+15 with gap idle cycles between them.
  task automatic send_map(input int base, input int gap);
    for (int i = 0; i < DEPTH; i++) begin
      in_data = DW'(base + i);
      in_en   = 1'b1;
      sb_q.push_back(model(in_data));
      @(posedge clk); #1;
      in_en = 1'b0;
      if (i < DEPTH - 1) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
  endtask

  // Drain the map. mode 0: ready always high; mode 1: ready pattern 1,0,0,1.
  // rst_at > 0: pulse reset after that many handshakes. ovf_inj: stray sample mid-drain.
  task automatic drain(input int mode, input int rst_at, input bit ovf_inj);
    logic [3:0]    pat;
    logic [DW-1:0] prev_d;
    logic [DW-1:0] exp_d;
    logic          exp_l;
    bit            prev_stall;
    int            hs;
    int            cyc;
    pat        = 4'b1001;
    prev_stall = 1'b0;
    prev_d     = {DW{1'b0}};
    hs         = 0;
    cyc        = 0;
    while (!done && cyc < 200) begin
      m_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
      if (ovf_inj && cyc == 3) begin
        in_en   = 1'b1;
        in_data = DW'(99);
      end else begin
        in_en = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) chk("lat_valid", m_valid, 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_d);
      end
      if (m_valid && m_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          exp_l = (sb_q.size() == 1);
          exp_d = sb_q.pop_front();
          chk("beat_data", m_data, exp_d);
          chk("beat_last", m_last, exp_l);
        end
        hs++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      @(posedge clk); #1;
      cyc++;
      if (rst_at > 0 && hs == rst_at) begin
        rst = 1'b0;
        in_en = 1'b0;
        #1;
        chk("rst_mvalid", m_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_mlast", m_last, 0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    in_en = 1'b0;
    chk("drain_done", done, 1);
    @(negedge clk);
    chk("done_mvalid", m_valid, 0);
    chk("hs_count", hs, DEPTH);
    chk("sb_empty", sb_q.size(), 0);
    if (mode == 0) chk("drain_cycles", cyc, DEPTH);
    @(posedge clk); #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clr_done", done, 0);
    chk("clr_mvalid", m_valid, 0);
    chk("clr_ovf", ovf, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; in_en = 1'b0; in_data = {DW{1'b0}}; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Happy path: sparse input, ready held high.
    m_ready = 1'b1;
    send_map(-8, 8);
    drain(0, 0, 1'b0);
    chk("happy_ovf", ovf, 0);
    chk("happy_done_hold", done, 1);
    do_clr();

    // Back-pressure.
    send_map(-8, 2);
    drain(1, 0, 1'b0);
    do_clr();

    // Overflow during drain.
    send_map(-8, 0);
    drain(0, 0, 1'b1);
    chk("ovf_set", ovf, 1);
    do_clr();

    // Reset mid-drain, then a fresh map with extreme positive values.
    send_map(100, 1);
    drain(0, 5, 1'b0);
    send_map(4080, 0);
    drain(1, 0, 1'b0);
    do_clr();

    // clr coinciding with the 10th sample in COLLECT.
    for (int i = 0; i < 9; i++) begin
      in_data = DW'(300 + i);
      in_en   = 1'b1;
      @(posedge clk); #1;
    end
    in_data = DW'(555);
    in_en   = 1'b1;
    clr     = 1'b1;
    @(posedge clk); #1;
    in_en = 1'b0;
    clr   = 1'b0;
    @(negedge clk);
    chk("clrcol_mvalid", m_valid, 0);
    @(posedge clk); #1;
    send_map(-20, 0);
    drain(0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_fmap_collector.md
# conv_fmap_collector

Sink-side partner of the convolution engine. It captures the serial result stream (`out` qualified by the one-cycle `out_en` pulse) into an (N-M+1)×(N-M+1) feature-map buffer. Once the map is complete, it replays the map on a valid/ready stream toward the next layer (pooling or FC) and flags completion. It sits directly downstream of the conv engine and decouples the engine's bursty output from a back-pressuring consumer.

## Interface
- `N`, default 6: input image side
- `M`, default 3: kernel side
- `DW`, default 13: signed sample width
- `clk  input  1`: sole clock; all logic on posedge
- `rst  input  1`: reset, asynchronous, active-low; clears all state and outputs
- `in_data  input  DW`: signed convolution result
- `in_en  input  1`: `in_data` valid this cycle (single-cycle pulse per result)
- `clr  input  1`: synchronous restart to COLLECT and empty buffer
- `m_data  output  DW`: signed feature-map element, row-major
- `m_valid  output  1`: `m_data` valid
- `m_ready  input  1`: consumer accepts
- `m_last  output  1`: high with final element (index O*O-1)
- `done  output  1`: map fully drained; held until `clr`/reset
- `ovf  output  1`: sticky; `in_en` seen outside COLLECT

## Operation
- O = N-M+1, DEPTH = O*O (16 at defaults). Counters `wr_cnt` and `rd_cnt` are clog2(DEPTH+1) bits.
- States: COLLECT (reset state), DRAIN, DONE.
- COLLECT:
  - On `in_en`, write `buf[wr_cnt]` and increment `wr_cnt`.
  - On the write that makes `wr_cnt`==DEPTH, go to DRAIN with `rd_cnt`=0.
  - `m_valid`=0 throughout.
- DRAIN:
  - `m_valid`=1, `m_data`=`buf[rd_cnt]`, `m_last`=(`rd_cnt`==DEPTH-1).
  - On `m_valid`&&`m_ready`, increment `rd_cnt`.
  - On the handshake with `m_last` set, go to DONE.
  - Data and valid must stay stable while `m_ready`=0.
- DONE: `m_valid`=0, `done`=1. Stays here until `clr`.
- `clr` (any state):
  - Next state COLLECT; `wr_cnt`, `rd_cnt`, `done`, `ovf`, `m_valid`, `m_last` all cleared.
  - Buffer contents need not be cleared.
- `in_en` in DRAIN or DONE: sample dropped, `ovf` set to 1.
- Simultaneous events:
  - `clr`+`in_en` in COLLECT: `clr` wins; sample discarded; `wr_cnt`=0.
  - `clr`+handshake in DRAIN: `clr` wins; handshake counts as consumed, but there is no further output.
- Arithmetic: values are stored as full DW-bit signed with no truncation; there is no saturation except as defined in Configuration.
- Reset mid-operation, in any state: immediate return to COLLECT, all outputs at reset values, and any partial map abandoned.

## Timing
- Reset values: `m_data`=0, `m_valid`=0, `m_last`=0, `done`=0, `ovf`=0; state COLLECT.
- Capture: a sample presented with `in_en` at edge t is stored at edge t.
- Collect-to-drain latency: the DEPTH-th `in_en` sampled at edge t gives `m_valid`=1 in the cycle after t, with element 0 on `m_data`.
- Zero-bubble drain: with `m_ready` held high, one element per cycle, DEPTH cycles total.
- The handshake with `m_last` at edge t gives `m_valid`=0 and `done`=1 in the cycle after t.
- `m_data`, `m_valid` and `m_last` are registered outputs; `m_ready` has no combinational path to any output.
- Input rate: `in_en` may be asserted every cycle, or sparsely.

## Configuration
- `CONV_RELU_EN` defined: ReLU is applied at capture. A negative `in_data` is stored as 0; non-negative values are stored unchanged.
- `CONV_RELU_EN` undefined: raw signed values are stored and replayed bit-exact.

## Structure
- Shared package `cnn_pkg`:
  - `DATA_W`=13
  - state enum `fmap_state_t` {COLLECT, DRAIN, DONE}
  - function `out_side(N,M)` returning N-M+1
- Sub-module `fmap_buf`: DEPTH×DW register array with one synchronous write port and one read port, instantiated once. Control FSM and counters live in the top.

## Test plan
- Happy path:
  - Stimulus: defaults, `m_ready`=1; push 16 pulses with values -8..7, each `in_en` separated by 8 idle cycles.
  - Required: 16 back-to-back beats in order; `m_last` only on value 7; `done`=1 the next cycle; `ovf`=0.
- Back-pressure:
  - Stimulus: same map; `m_ready` toggled 1,0,0,1 repeatedly.
  - Required: no loss or duplication; `m_data` stable while stalled; exactly 16 handshakes.
- ReLU:
  - Stimulus: `CONV_RELU_EN` defined, inputs -8..7.
  - Required: beats 0 (×8), then 0..7; undefined build replays -8..7.
- Overflow:
  - Stimulus: a 17th `in_en` (value 99) arrives during DRAIN.
  - Required: `ovf`=1 sticky; output stream unchanged.
  - Follow-up: `clr` sets `ovf`=0.
- Reset mid-drain:
  - Stimulus: assert `rst`=0 after the 5th handshake.
  - Required: `m_valid`=0, `done`=0 immediately.
  - Follow-up: a new 16-sample map collects and drains correctly.
- `clr` in COLLECT:
  - Stimulus: `clr` together with the 10th `in_en`.
  - Required: `wr_cnt`=0; the next 16 samples form the drained map.
